// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, control FSM state encoding and datapath mux encodings.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PcPlus4 = 2'b00,
    PcImm   = 2'b01,
    PcAlu   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc4 = 2'b10,
    WbImm = 2'b11
  } wb_sel_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from funct3 and the ALU compare flags; purely combinational.
module branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       alu_zero_i,
  input  logic       alu_lt_i,
  input  logic       alu_ltu_i,
  output logic       taken_o,
  output logic       bad_funct3_o
);

  always_comb begin
    taken_o      = 1'b0;
    bad_funct3_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = alu_zero_i;
      3'b001:  taken_o = ~alu_zero_i;
      3'b100:  taken_o = alu_lt_i;
      3'b101:  taken_o = ~alu_lt_i;
      3'b110:  taken_o = alu_ltu_i;
      3'b111:  taken_o = ~alu_ltu_i;
      default: bad_funct3_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/wb and the shared memory port,
// with sticky illegal-opcode and bus-timeout traps.
module multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam bit               TimeoutEn  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic    mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c;
  logic    alu_a_sel_c, alu_b_sel_c, rf_we_c;
  pc_sel_e pc_sel_c;
  wb_sel_e wb_sel_c;

  logic [6:0] opcode;
  logic       rd_nz, taken, bad_funct3, timeout_hit;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign rd_nz        = |instr[11:7];
  assign unused_instr = ^instr[31:15];

  branch_cond u_branch_cond (
    .funct3_i     (instr[14:12]),
    .alu_zero_i   (alu_zero),
    .alu_lt_i     (alu_lt),
    .alu_ltu_i    (alu_ltu),
    .taken_o      (taken),
    .bad_funct3_o (bad_funct3)
  );

  // The wait that would bring the counter to TIMEOUT traps, unless mem_ack arrives in it.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutCnt);

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = PcPlus4;
    alu_a_sel_c = 1'b0;
    alu_b_sel_c = 1'b0;
    rf_we_c     = 1'b0;
    wb_sel_c    = WbAlu;

    case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          ir_we_c = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StDecode: begin
        if (is_legal_opcode(opcode)) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StExec: begin
        state_d = StWb;
        case (opcode)
          OP_I, OP_JALR: alu_b_sel_c = 1'b1;
          OP_LOAD, OP_STORE: begin
            alu_b_sel_c = 1'b1;
            state_d     = StMem;
          end
          OP_AUIPC: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 1'b1;
          end
          OP_BRANCH: begin
            if (bad_funct3) begin
              illegal_d = 1'b1;
              state_d   = StTrap;
            end else begin
              pc_we_c  = 1'b1;
              pc_sel_c = taken ? PcImm : PcPlus4;
              state_d  = StFetch;
            end
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (opcode == OP_STORE);
        if (mem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we_c = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StWb: begin
        rf_we_c = rd_nz;
        pc_we_c = 1'b1;
        state_d = StFetch;
        case (opcode)
          OP_LOAD: wb_sel_c = WbMem;
          OP_LUI:  wb_sel_c = WbImm;
          OP_JAL: begin
            wb_sel_c = WbPc4;
            pc_sel_c = PcImm;
          end
          OP_JALR: begin
            // JALR target comes straight off the ALU, so its EXEC operands stay selected.
            wb_sel_c    = WbPc4;
            pc_sel_c    = PcAlu;
            alu_b_sel_c = 1'b1;
          end
          default: ;
        endcase
      end
      StTrap: ;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
      cnt_d = '0;
    end else if (mem_req_c && !mem_ack) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every output is forced low while reset is asserted, whatever state the FSM was in.
  assign mem_req   = mem_req_c & ~reset;
  assign mem_we    = mem_we_c & ~reset;
  assign addr_sel  = addr_sel_c & ~reset;
  assign ir_we     = ir_we_c & ~reset;
  assign pc_we     = pc_we_c & ~reset;
  assign pc_sel    = pc_sel_c & {2{~reset}};
  assign alu_a_sel = alu_a_sel_c & ~reset;
  assign alu_b_sel = alu_b_sel_c & ~reset;
  assign rf_we     = rf_we_c & ~reset;
  assign wb_sel    = wb_sel_c & {2{~reset}};
  assign illegal   = illegal_q & ~reset;
  assign bus_err   = bus_err_q & ~reset;
  assign state     = state_q & {3{~reset}};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table plus hand-built corner sequences, scoreboard-checked.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    outs_t exp;
    outs_t mask;
    string tag;
    int    idx;
  } sb_t;

  typedef struct {
    string           name;
    logic [31:0]     instr;
    logic            zero;
    logic            lt;
    logic            ltu;
    int              n;
    outs_t [4:0]     exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ack, alu_zero, alu_lt, alu_ltu;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we;
  logic        illegal, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  outs_t       act;

  int checks   = 0;
  int failures = 0;
  sb_t  sb[$];
  sb_t  cur;
  vec_t vecs[$];

  localparam outs_t All = '1;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ack   (mem_ack),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .alu_ltu   (alu_ltu),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state     (state)
  );

  assign act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we,
                wb_sel, illegal, bus_err, state};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checks++;
      if ((act & cur.mask) !== (cur.exp & cur.mask)) begin
        failures++;
        $display("FAIL %s[%0d]: got=%h want=%h mask=%h", cur.tag, cur.idx, act, cur.exp,
                 cur.mask);
      end
    end
  end

  function automatic outs_t o_st(input logic [2:0] s);
    outs_t o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic ack);
    outs_t o = o_st(3'd0);
    o.mem_req = 1'b1;
    o.ir_we   = ack;
    return o;
  endfunction

  function automatic outs_t o_exec(input logic a, input logic b, input logic pcwe,
                                   input logic [1:0] pcs);
    outs_t o = o_st(3'd2);
    o.alu_a_sel = a;
    o.alu_b_sel = b;
    o.pc_we     = pcwe;
    o.pc_sel    = pcs;
    return o;
  endfunction

  function automatic outs_t o_mem(input logic we, input logic ack);
    outs_t o = o_st(3'd3);
    o.mem_req  = 1'b1;
    o.addr_sel = 1'b1;
    o.mem_we   = we;
    o.pc_we    = we & ack;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic rf, input logic [1:0] wbs, input logic [1:0] pcs,
                                 input logic b);
    outs_t o = o_st(3'd4);
    o.rf_we     = rf;
    o.pc_we     = 1'b1;
    o.wb_sel    = wbs;
    o.pc_sel    = pcs;
    o.alu_b_sel = b;
    return o;
  endfunction

  function automatic outs_t o_trap(input logic ill, input logic be);
    outs_t o = o_st(3'd5);
    o.illegal = ill;
    o.bus_err = be;
    return o;
  endfunction

  task automatic add_vec(input string name, input logic [31:0] ins, input logic z,
                         input logic l, input logic lu, input int n, input outs_t e2,
                         input outs_t e3, input outs_t e4);
    vec_t v;
    v.name  = name;
    v.instr = ins;
    v.zero  = z;
    v.lt    = l;
    v.ltu   = lu;
    v.n     = n;
    v.exp   = {e4, e3, e2, o_st(3'd1), o_fetch(1'b1)};
    vecs.push_back(v);
  endtask

  // Called at posedge+1: drive, queue the expectation, advance to the next posedge+1.
  task automatic drive(input logic ack, input outs_t exp, input outs_t mask, input string tag,
                       input int idx);
    mem_ack = ack;
    sb.push_back('{exp: exp, mask: mask, tag: tag, idx: idx});
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input logic [2:0] exp_state, input logic exp_ill,
                           input logic exp_be, input string tag);
    checks++;
    if ((state !== exp_state) || (illegal !== exp_ill) || (bus_err !== exp_be)) begin
      failures++;
      $display("FAIL %s: state=%0d illegal=%b bus_err=%b want state=%0d illegal=%b bus_err=%b",
               tag, state, illegal, bus_err, exp_state, exp_ill, exp_be);
    end
  endtask

  initial begin
    reset    = 1'b1;
    instr    = '0;
    mem_ack  = 1'b0;
    alu_zero = 1'b0;
    alu_lt   = 1'b0;
    alu_ltu  = 1'b0;

    add_vec("addi", 32'h00500093, 0, 0, 0, 4, o_exec(0, 1, 0, 2'b00),
            o_wb(1, 2'b00, 2'b00, 0), '0);
    add_vec("add_x3", 32'h002081B3, 0, 0, 0, 4, o_exec(0, 0, 0, 2'b00),
            o_wb(1, 2'b00, 2'b00, 0), '0);
    add_vec("add_x0", 32'h00208033, 0, 0, 0, 4, o_exec(0, 0, 0, 2'b00),
            o_wb(0, 2'b00, 2'b00, 0), '0);
    add_vec("beq_t", 32'h00208463, 1, 0, 0, 3, o_exec(0, 0, 1, 2'b01), '0, '0);
    add_vec("beq_nt", 32'h00208463, 0, 0, 0, 3, o_exec(0, 0, 1, 2'b00), '0, '0);
    add_vec("bne_t", 32'h00209463, 0, 1, 1, 3, o_exec(0, 0, 1, 2'b01), '0, '0);
    add_vec("blt_t", 32'h0020C463, 0, 1, 0, 3, o_exec(0, 0, 1, 2'b01), '0, '0);
    add_vec("blt_nt", 32'h0020C463, 1, 0, 1, 3, o_exec(0, 0, 1, 2'b00), '0, '0);
    add_vec("bge_nt", 32'h0020D463, 0, 1, 0, 3, o_exec(0, 0, 1, 2'b00), '0, '0);
    add_vec("bltu_nt", 32'h0020E463, 0, 1, 0, 3, o_exec(0, 0, 1, 2'b00), '0, '0);
    add_vec("bgeu_t", 32'h0020F463, 0, 1, 0, 3, o_exec(0, 0, 1, 2'b01), '0, '0);
    add_vec("lui", 32'h123452B7, 0, 0, 0, 4, o_exec(0, 0, 0, 2'b00),
            o_wb(1, 2'b11, 2'b00, 0), '0);
    add_vec("auipc", 32'h00001317, 0, 0, 0, 4, o_exec(1, 1, 0, 2'b00),
            o_wb(1, 2'b00, 2'b00, 0), '0);
    add_vec("jal", 32'h008000EF, 0, 0, 0, 4, o_exec(0, 0, 0, 2'b00),
            o_wb(1, 2'b10, 2'b01, 0), '0);
    add_vec("jalr", 32'h000100E7, 0, 0, 0, 4, o_exec(0, 1, 0, 2'b00),
            o_wb(1, 2'b10, 2'b10, 1), '0);
    add_vec("lw", 32'h0000A203, 0, 0, 0, 5, o_exec(0, 1, 0, 2'b00), o_mem(0, 1),
            o_wb(1, 2'b01, 2'b00, 0));
    add_vec("sw", 32'h0020A023, 0, 0, 0, 4, o_exec(0, 1, 0, 2'b00), o_mem(1, 1), '0);

    @(posedge clk);
    #1;
    drive(1'b0, '0, All, "reset", 0);
    drive(1'b1, '0, All, "reset", 1);
    reset = 1'b0;
    #1;
    check_now(3'd0, 1'b0, 1'b0, "reset_state");

    foreach (vecs[i]) begin
      instr    = vecs[i].instr;
      alu_zero = vecs[i].zero;
      alu_lt   = vecs[i].lt;
      alu_ltu  = vecs[i].ltu;
      for (int c = 0; c < vecs[i].n; c++) drive(1'b1, vecs[i].exp[c], All, vecs[i].name, c);
    end

    // Load with 3 fetch waits (ack lands as the counter would hit TIMEOUT) and 3 MEM waits.
    instr = 32'h0000A203;
    for (int c = 0; c < 3; c++) drive(1'b0, o_fetch(1'b0), All, "lw_slow_fetch", c);
    drive(1'b1, o_fetch(1'b1), All, "lw_slow_fetch", 3);
    drive(1'b0, o_st(3'd1), All, "lw_slow_dec", 0);
    drive(1'b0, o_exec(0, 1, 0, 2'b00), All, "lw_slow_exec", 0);
    for (int c = 0; c < 3; c++) drive(1'b0, o_mem(0, 0), All, "lw_slow_mem", c);
    drive(1'b1, o_mem(0, 1), All, "lw_slow_mem", 3);
    drive(1'b0, o_wb(1, 2'b01, 2'b00, 0), All, "lw_slow_wb", 0);

    // Illegal opcode: trap holds with every enable low, whatever mem_ack does.
    instr = 32'h0000007F;
    drive(1'b1, o_fetch(1'b1), All, "ill_fetch", 0);
    drive(1'b0, o_st(3'd1), All, "ill_dec", 0);
    for (int c = 0; c < 20; c++) drive(1'($urandom_range(0, 1)), o_trap(1, 0), All, "ill_trap", c);
    reset = 1'b1;
    drive(1'b1, '0, All, "ill_reset", 0);
    reset = 1'b0;
    drive(1'b0, o_fetch(1'b0), All, "ill_after_reset", 0);

    // Branch with funct3=010 traps as illegal.
    instr    = 32'h0020A463;
    alu_zero = 1'b1;
    drive(1'b1, o_fetch(1'b1), All, "badbr_fetch", 0);
    drive(1'b0, o_st(3'd1), All, "badbr_dec", 0);
    drive(1'b0, o_st(3'd2), o_st(3'd7), "badbr_exec", 0);
    for (int c = 0; c < 20; c++) drive(1'b1, o_trap(1, 0), All, "badbr_trap", c);
    reset = 1'b1;
    drive(1'b0, '0, All, "badbr_reset", 0);
    reset = 1'b0;

    // Fetch timeout: four unanswered request cycles, then a bus-error trap.
    instr = 32'h00500093;
    for (int c = 0; c < 4; c++) drive(1'b0, o_fetch(1'b0), All, "to_fetch", c);
    for (int c = 0; c < 3; c++) drive(1'b0, o_trap(0, 1), All, "to_trap", c);
    check_now(3'd5, 1'b0, 1'b1, "timeout_expired");
    reset = 1'b1;
    drive(1'b0, '0, All, "to_reset", 0);
    reset = 1'b0;

    // Reset in the middle of a load's MEM wait.
    instr = 32'h0000A203;
    drive(1'b1, o_fetch(1'b1), All, "rmem_fetch", 0);
    drive(1'b0, o_st(3'd1), All, "rmem_dec", 0);
    drive(1'b0, o_exec(0, 1, 0, 2'b00), All, "rmem_exec", 0);
    for (int c = 0; c < 2; c++) drive(1'b0, o_mem(0, 0), All, "rmem_mem", c);
    reset = 1'b1;
    drive(1'b1, '0, All, "rmem_reset", 0);
    reset = 1'b0;
    drive(1'b0, o_fetch(1'b0), All, "rmem_after", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the multicycle RISC-V RV32I datapath: instruction fetch, decode, execute, memory access and write-back.
- Drives the datapath selects and write enables, including the immediate-operand select that steers the ImmGen output into the ALU or write-back mux.
- Runs a req/ack handshake to the shared instruction/data memory port, with a bus timeout.
- Sits between the instruction register and the datapath; the only sequential control in the core.

Parameters:
- TIMEOUT, 16, max cycles a memory request waits for mem_ack before trapping; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction register contents; valid from DECODE onward.
- mem_ack  in  1  memory completion; ignored when mem_req=0.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2.
- alu_ltu  in  1  unsigned rs1 < rs2.
- mem_req  out  1  memory request.
- mem_we  out  1  store strobe; valid only while mem_req=1.
- addr_sel  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC write.
- pc_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result with bit0 cleared (JALR).
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- rf_we  out  1  register file write.
- wb_sel  out  2  00 = ALU, 01 = mem rdata, 10 = PC+4, 11 = imm (LUI).
- illegal  out  1  sticky flag: illegal opcode trap.
- bus_err  out  1  sticky flag: memory timeout trap.
- state  out  3  current state, for debug.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high. On a reset edge: state = FETCH, timeout counter = 0, illegal = 0, bus_err = 0. While reset is high, all outputs are 0. Reset in any state, including mid-MEM, drops mem_req on the next edge with no partial PC or register file write.
- All outputs are combinational from state and instr (Moore/Mealy mix). Unless listed below, every enable is 0 and every select is 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.

State actions:
- FETCH: mem_req=1, addr_sel=0.
  - Without mem_ack: stay in FETCH.
  - On mem_ack: ir_we=1, go to DECODE.
- DECODE: one cycle. Decode opcode instr[6:0].
  - Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
  - Any other opcode: go to TRAP with illegal=1. Otherwise go to EXEC.
- EXEC: one cycle.
  - R-type: alu_b_sel=0.
  - I-type ALU, load, store, JALR: alu_b_sel=1.
  - AUIPC: alu_a_sel=1, alu_b_sel=1.
  - Branch: pc_we=1. pc_sel=01 if taken, else 00. Go to FETCH.
    - Taken condition by funct3 = instr[14:12]: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - funct3 010 or 011: go to TRAP with illegal=1.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, addr_sel=1; mem_we=1 for store. Outputs are held stable until mem_ack.
  - Store on mem_ack: pc_we=1, pc_sel=00, go to FETCH.
  - Load on mem_ack: go to WB.
- WB: rf_we=1 unless instr[11:7]==0. pc_we=1. Then go to FETCH.
  - ALU and AUIPC: wb_sel=00, pc_sel=00.
  - Load: wb_sel=01, pc_sel=00.
  - LUI: wb_sel=11, pc_sel=00.
  - JAL: wb_sel=10, pc_sel=01.
  - JALR: wb_sel=10, pc_sel=10. The ALU operands from EXEC are held through WB.
- TRAP: all enables 0. illegal and bus_err hold their values. Stays in TRAP until reset.

Timeout:
- The counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 and mem_ack=0.
- If TIMEOUT != 0 and the counter reaches TIMEOUT without an ack: go to TRAP, bus_err=1, mem_req drops.
- An ack in the same cycle the counter reaches TIMEOUT wins; no trap.

Latency:
- Branch: 3 cycles + fetch wait.
- ALU op: 4 cycles + fetch wait.
- Load: 5 cycles + fetch wait + MEM wait.

Decomposition:
- Shared package rv_pkg, containing:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR), shared with ImmGen decode;
  - state enum;
  - pc_sel and wb_sel encodings.
- One sub-module, branch_cond: funct3, alu_zero, alu_lt, alu_ltu -> taken, bad_funct3. Purely combinational.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ack every request -> states 0,1,2,4,0. In EXEC alu_b_sel=1. In WB rf_we=1, wb_sel=00, pc_we=1, pc_sel=00.
- beq with alu_zero=1, then with alu_zero=0 -> EXEC asserts pc_we=1 with pc_sel=01, then 00. No WB state and rf_we never set.
- lw with mem_ack delayed 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles. Then WB with wb_sel=01, rf_we=1.
- sw (0x0020A023) -> MEM with mem_we=1. On ack, pc_we=1 with pc_sel=00, rf_we=0, back to FETCH.
- Opcode 0x7F, and separately branch funct3=010 -> illegal=1, state=5, all enables 0 for 20 cycles. Reset returns state=0 with illegal=0.
- TIMEOUT=4 with mem_ack held low in FETCH -> bus_err=1 after 4 cycles. Separately, reset asserted mid-MEM -> mem_req=0 and state=0 the next cycle.
